alu_control_pipe: RTL and testbench
===================================

Name: alu_control_pipe

Overview:
Registered, parametrised successor to the combinational ALU control decoder in the EX stage of the MIPS pipeline. Decodes ALUOp/funct into an ALU control code, one cycle after the instruction is accepted. Extends the decoder with:
- a 3-bit ALUOp, so immediate logic ops and LUI decode without a funct field.
- an illegal-funct flag, in place of undefined outputs.
- a multi-cycle mult/div sequencer that back-pressures issue for a programmable number of cycles.

Parameters:
CTRL_W, 4, width of alu_ctrl; must be >= 4; codes are zero-extended into the upper bits.
MUL_CYCLES, 4, busy cycles after a mult/multu is captured; must be >= 1.
DIV_CYCLES, 32, busy cycles after a div/divu is captured; must be >= 1.
CNT_W, 6, busy counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  decode request valid.
in_ready  out  1  block can accept this cycle.
alu_op  in  3  ALUOp from main control.
funct  in  6  instruction bits [5:0].
stall  in  1  pipeline hold; freezes the output register.
flush  in  1  kill the captured op and any running mult/div.
out_valid  out  1  alu_ctrl/illegal valid.
alu_ctrl  out  CTRL_W  decoded ALU control code.
illegal  out  1  R-type funct not recognised.
md_busy  out  1  mult/div sequencer active.
md_done  out  1  one-cycle pulse when the mult/div busy period ends.

Behaviour:
- Reset values (clock edge with rst_n=0): out_valid=0, alu_ctrl=0, illegal=0, md_busy=0, md_done=0, FSM=IDLE, counter=0. Reset overrides flush and stall; reset mid-busy returns to IDLE with no md_done.
- in_ready = (FSM==IDLE) && !stall. This is combinational.
- Accept = in_valid && in_ready. On accept, the next edge loads alu_ctrl/illegal and sets out_valid=1 (latency 1).
- No accept and no stall: next edge sets out_valid=0; alu_ctrl and illegal hold their last value.
- stall=1 (no flush): output register holds all values; no accept.
- flush=1: next edge sets out_valid=0, illegal=0, FSM→IDLE, counter=0, md_done=0. Flush beats stall and accept; the flush-cycle input is discarded.
- ALUOp decode (code in 4 bits):
  - 000 add 0000; 001 sub 0001; 010 R-type (see funct); 011 and 0010; 100 or 0011; 101 slt 1000; 110 xor 0110; 111 lui 1011.
- Funct decode for ALUOp=010:
  - 100000/100001 add 0000; 100010/100011 sub 0001.
  - 100100 and 0010; 100101 or 0011; 100110 xor 0110; 100111 nor 1001.
  - 101010 slt 1000; 101011 sltu 1010.
  - 000000 sll 0100; 000010 srl 0101; 000011 sra 0111.
  - 011000 mult 1100; 011001 multu 1101; 011010 div 1110; 011011 divu 1111.
  - Any other funct: alu_ctrl=0000, illegal=1, out_valid=1.
- FSM states: IDLE, MD_BUSY.
  - IDLE→MD_BUSY on accept of a code in 1100–1111. Counter loads MUL_CYCLES-1 for 1100/1101, DIV_CYCLES-1 for 1110/1111.
  - MD_BUSY: the counter decrements every cycle, independent of stall.
  - MD_BUSY, counter==0: next edge →IDLE and md_done=1 for exactly that one cycle.
  - md_busy = (FSM==MD_BUSY).
  - in_ready is low for exactly N cycles after the capturing edge (N = MUL_CYCLES or DIV_CYCLES).
  - flush in MD_BUSY aborts: →IDLE, no md_done pulse.
- Simultaneous events:
  - md_done cycle: FSM is already IDLE, so a new accept is legal in the same cycle.
  - Back-to-back mults: the second is accepted on the md_done cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, alu_op=010, funct=100000. Require all outputs 0 and in_ready=1 once rst_n=1 (stall=0).
- R-type sweep: one accept per cycle over all 17 legal functs, then funct=111111. Require the listed codes one cycle after each accept with illegal=0; the last gives alu_ctrl=0000, illegal=1.
- Stall: accept alu_op=011, then stall=1 for 3 cycles with a new in_valid. Require out_valid=1, alu_ctrl=0010 held, in_ready=0; release gives out_valid=0, then the new op captured.
- Mult, MUL_CYCLES=4: accept funct=011000 at edge T. Require:
  - alu_ctrl=1100 after T.
  - in_ready=0 and md_busy=1 for 4 cycles.
  - md_done=1 on the 4th.
  - A second mult accepted in the md_done cycle.
- Div flush, DIV_CYCLES=32: accept divu, flush at busy cycle 10. Require the next edge gives md_busy=0, out_valid=0, in_ready=1, and md_done never asserted.
- Immediate ops: alu_op=110 and 111 in sequence. Require alu_ctrl=0110, then 1011; CTRL_W=6 gives 000110 / 001011.

Source files
------------

// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder for the EX stage.
// Decodes ALUOp/funct one cycle after accept, flags unknown R-type functs and
// sequences multi-cycle mult/div ops by holding off issue while they run.
module alu_control_pipe #(
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              md_busy,
    output logic              md_done
);

    typedef enum logic [0:0] {StIdle, StMdBusy} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              md_done_q, md_done_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              illegal_q, illegal_d;

    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       accept;
    logic       dec_is_md;

    // Combinational decode of ALUOp and, for R-type, the funct field.
    always_comb begin
        dec_code    = 4'b0000;
        dec_illegal = 1'b0;
        unique case (alu_op)
            3'b000: dec_code = 4'b0000;
            3'b001: dec_code = 4'b0001;
            3'b011: dec_code = 4'b0010;
            3'b100: dec_code = 4'b0011;
            3'b101: dec_code = 4'b1000;
            3'b110: dec_code = 4'b0110;
            3'b111: dec_code = 4'b1011;
            3'b010: begin
                case (funct)
                    6'b100000, 6'b100001: dec_code = 4'b0000;
                    6'b100010, 6'b100011: dec_code = 4'b0001;
                    6'b100100:            dec_code = 4'b0010;
                    6'b100101:            dec_code = 4'b0011;
                    6'b100110:            dec_code = 4'b0110;
                    6'b100111:            dec_code = 4'b1001;
                    6'b101010:            dec_code = 4'b1000;
                    6'b101011:            dec_code = 4'b1010;
                    6'b000000:            dec_code = 4'b0100;
                    6'b000010:            dec_code = 4'b0101;
                    6'b000011:            dec_code = 4'b0111;
                    6'b011000:            dec_code = 4'b1100;
                    6'b011001:            dec_code = 4'b1101;
                    6'b011010:            dec_code = 4'b1110;
                    6'b011011:            dec_code = 4'b1111;
                    default: begin
                        dec_code    = 4'b0000;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_code = 4'b0000;
        endcase
    end

    assign in_ready  = (state_q == StIdle) && !stall;
    assign accept    = in_valid && in_ready;
    // Only the mult/div functs decode into the 11xx range.
    assign dec_is_md = (dec_code[3:2] == 2'b11);

    // Mult/div sequencer next state; the counter runs regardless of stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_done_d = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept && dec_is_md) begin
                        state_d = StMdBusy;
                        cnt_d   = dec_code[1] ? CNT_W'(DIV_CYCLES - 1)
                                              : CNT_W'(MUL_CYCLES - 1);
                    end
                end
                StMdBusy: begin
                    if (cnt_q == '0) begin
                        state_d   = StIdle;
                        md_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output register next state: flush beats stall beats accept.
    always_comb begin
        out_valid_d = out_valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (stall) begin
            out_valid_d = out_valid_q;
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_ctrl_d  = CTRL_W'(dec_code);
            illegal_d   = dec_illegal;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            md_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_done_q   <= md_done_d;
            out_valid_q <= out_valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign illegal   = illegal_q;
    assign md_busy   = (state_q == StMdBusy);
    assign md_done   = md_done_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: decode table sweep plus hand-written
// stall, mult back-to-back, div flush and immediate-op sequences.
module tb_alu_control_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] alu_op = 3'b000;
    logic [5:0] funct = 6'b000000;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic [3:0] alu_ctrl;
    logic       illegal;
    logic       md_busy;
    logic       md_done;

    logic       in_ready6, out_valid6, illegal6, md_busy6, md_done6;
    logic [5:0] alu_ctrl6;

    int checks = 0;
    int errors = 0;

    alu_control_pipe #(
        .CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .stall(stall), .flush(flush),
        .out_valid(out_valid), .alu_ctrl(alu_ctrl), .illegal(illegal),
        .md_busy(md_busy), .md_done(md_done)
    );

    alu_control_pipe #(
        .CTRL_W(6), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)
    ) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
        .alu_op(alu_op), .funct(funct), .stall(stall), .flush(flush),
        .out_valid(out_valid6), .alu_ctrl(alu_ctrl6), .illegal(illegal6),
        .md_busy(md_busy6), .md_done(md_done6)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] code;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits with in_valid low until the block is ready again, bounded.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int     n;
        logic   seen_done;

        // R-type functs, then illegal ones, then every non-R ALUOp.
        vecs.push_back({3'b010, 6'b100000, 4'b0000, 1'b0});
        vecs.push_back({3'b010, 6'b100001, 4'b0000, 1'b0});
        vecs.push_back({3'b010, 6'b100010, 4'b0001, 1'b0});
        vecs.push_back({3'b010, 6'b100011, 4'b0001, 1'b0});
        vecs.push_back({3'b010, 6'b100100, 4'b0010, 1'b0});
        vecs.push_back({3'b010, 6'b100101, 4'b0011, 1'b0});
        vecs.push_back({3'b010, 6'b100110, 4'b0110, 1'b0});
        vecs.push_back({3'b010, 6'b100111, 4'b1001, 1'b0});
        vecs.push_back({3'b010, 6'b101010, 4'b1000, 1'b0});
        vecs.push_back({3'b010, 6'b101011, 4'b1010, 1'b0});
        vecs.push_back({3'b010, 6'b000000, 4'b0100, 1'b0});
        vecs.push_back({3'b010, 6'b000010, 4'b0101, 1'b0});
        vecs.push_back({3'b010, 6'b000011, 4'b0111, 1'b0});
        vecs.push_back({3'b010, 6'b011000, 4'b1100, 1'b0});
        vecs.push_back({3'b010, 6'b011001, 4'b1101, 1'b0});
        vecs.push_back({3'b010, 6'b011010, 4'b1110, 1'b0});
        vecs.push_back({3'b010, 6'b011011, 4'b1111, 1'b0});
        vecs.push_back({3'b010, 6'b111111, 4'b0000, 1'b1});
        vecs.push_back({3'b010, 6'b000001, 4'b0000, 1'b1});
        vecs.push_back({3'b000, 6'b111111, 4'b0000, 1'b0});
        vecs.push_back({3'b001, 6'b111111, 4'b0001, 1'b0});
        vecs.push_back({3'b011, 6'b000000, 4'b0010, 1'b0});
        vecs.push_back({3'b100, 6'b000000, 4'b0011, 1'b0});
        vecs.push_back({3'b101, 6'b000000, 4'b1000, 1'b0});
        vecs.push_back({3'b110, 6'b000000, 4'b0110, 1'b0});
        vecs.push_back({3'b111, 6'b000000, 4'b1011, 1'b0});

        // Reset with a valid request pending.
        rst_n = 1'b0; in_valid = 1'b1; alu_op = 3'b010; funct = 6'b100000;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_md_done", 32'(md_done), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Decode table sweep, one accept per vector.
        for (int i = 0; i < vecs.size(); i++) begin
            wait_ready("sweep");
            in_valid = 1'b1; alu_op = vecs[i].op; funct = vecs[i].fn;
            tick();
            in_valid = 1'b0;
            chk($sformatf("sweep%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("sweep%0d_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].code));
            chk($sformatf("sweep%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
        end
        wait_ready("sweep_end");
        tick();

        // Stall holds the output register and blocks issue.
        in_valid = 1'b1; alu_op = 3'b011; funct = 6'b000000;
        tick();
        chk("stall_cap_ctrl", 32'(alu_ctrl), 32'd2);
        stall = 1'b1; alu_op = 3'b100;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_ctrl", k), 32'(alu_ctrl), 32'd2);
            chk($sformatf("stall%0d_ready", k), 32'(in_ready), 32'd0);
        end
        stall = 1'b0; in_valid = 1'b0;
        tick();
        chk("stall_rel_valid", 32'(out_valid), 32'd0);
        chk("stall_rel_ctrl_hold", 32'(alu_ctrl), 32'd2);
        in_valid = 1'b1;
        tick();
        chk("stall_new_valid", 32'(out_valid), 32'd1);
        chk("stall_new_ctrl", 32'(alu_ctrl), 32'd3);
        in_valid = 1'b0;
        tick();

        // Mult: four busy cycles, done pulse, back-to-back multu accepted.
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b011000;
        tick();
        chk("mul_ctrl", 32'(alu_ctrl), 32'hC);
        funct = 6'b011001;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("mul_busy%0d", k), 32'(md_busy), 32'd1);
            chk($sformatf("mul_ready%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("mul_done%0d", k), 32'(md_done), 32'd0);
            tick();
        end
        chk("mul_end_busy", 32'(md_busy), 32'd0);
        chk("mul_end_done", 32'(md_done), 32'd1);
        chk("mul_end_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("mul2_ctrl", 32'(alu_ctrl), 32'hD);
        chk("mul2_valid", 32'(out_valid), 32'd1);
        chk("mul2_busy", 32'(md_busy), 32'd1);
        chk("mul2_done_clear", 32'(md_done), 32'd0);
        wait_ready("mul2");
        tick();

        // Divu flushed in busy cycle 10: abort with no done pulse.
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b011011;
        tick();
        in_valid = 1'b0;
        chk("div_ctrl", 32'(alu_ctrl), 32'hF);
        seen_done = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            seen_done = seen_done | md_done;
        end
        chk("div_busy10", 32'(md_busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("div_flush_busy", 32'(md_busy), 32'd0);
        chk("div_flush_valid", 32'(out_valid), 32'd0);
        chk("div_flush_ready", 32'(in_ready), 32'd1);
        n = 0;
        while (n < 30) begin
            seen_done = seen_done | md_done;
            tick();
            n++;
        end
        chk("div_no_done", 32'(seen_done), 32'd0);

        // Flush clears illegal and discards the flush-cycle input.
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b111110;
        tick();
        chk("ill_set", 32'(illegal), 32'd1);
        flush = 1'b1; alu_op = 3'b001;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_illegal", 32'(illegal), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ctrl_hold", 32'(alu_ctrl), 32'd0);
        tick();

        // Immediate logic ops, also on the 6-bit wide instance.
        in_valid = 1'b1; alu_op = 3'b110;
        tick();
        chk("imm_xor", 32'(alu_ctrl), 32'h6);
        chk("imm_xor_w6", 32'(alu_ctrl6), 32'h06);
        alu_op = 3'b111;
        tick();
        in_valid = 1'b0;
        chk("imm_lui", 32'(alu_ctrl), 32'hB);
        chk("imm_lui_w6", 32'(alu_ctrl6), 32'h0B);

        // Reset mid-busy returns to idle without a done pulse.
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b011000;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy_cleared", 32'(md_busy), 32'd0);
        chk("rst_busy_valid", 32'(out_valid), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen_done = seen_done | md_done;
            tick();
        end
        chk("rst_busy_no_done", 32'(seen_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
